alu_arbiter: RTL
================

# alu_arbiter

Two-port arbiter that shares the single-cycle datapath ALU between two requesters, for example the EX-stage issue and an address or branch helper unit. Each requester presents an ALU operation (S1, S2, ALUControl) with a valid/ready handshake. The block grants at most one operation per cycle using round-robin priority, drives the shared ALU combinationally, and captures ALUResult/Zero into that requester's one-entry response buffer. The ALU itself is instantiated outside this block; only its ports are wired through here.

## Interface
- `W`, default 32: operand and result width.
- `CW`, default 3: ALUControl width.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1 each: operation offered.
- `req0_ready`, `req1_ready` out 1 each: operation granted this cycle (combinational).
- `req0_s1`, `req0_s2`, `req1_s1`, `req1_s2` in W each: operands.
- `req0_ctrl`, `req1_ctrl` in CW each: ALUControl code, passed through unmodified.
- `rsp0_valid`, `rsp1_valid` out 1 each: response buffer full.
- `rsp0_ready`, `rsp1_ready` in 1 each: requester consumes the response.
- `rsp0_result`, `rsp1_result` out W each: registered ALUResult.
- `rsp0_zero`, `rsp1_zero` out 1 each: registered Zero.
- `alu_s1`, `alu_s2` out W each: to ALU S1/S2.
- `alu_ctrl` out CW: to ALU ALUControl.
- `alu_result` in W, `alu_zero` in 1: from the ALU.

## Operation
- State:
  - `last` (1 bit): last granted requester.
  - Per requester, one response buffer: `rspN_valid` flag plus result and zero registers.
- Eligibility of requester N: `reqN_valid & (!rspN_valid | rspN_ready)`. A full buffer that is drained in the same cycle counts as free.
- Grant rules:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester that is not `last`.
  - Neither eligible: no grant.
  - `reqN_ready` equals the grant to N. It never asserts without `reqN_valid`.
- While a requester is granted, `alu_s1`, `alu_s2` and `alu_ctrl` carry its operands. With no grant they are driven to 0.
- On a grant to N at the clock edge:
  - `rspN_result` ← `alu_result`, `rspN_zero` ← `alu_zero`, `rspN_valid` ← 1.
  - `last` ← N.
- Response drain: `rspN_valid & rspN_ready & !grantN` clears `rspN_valid`. Result and zero hold their last values.
- Simultaneous drain and grant to the same N: the new result is written and `rspN_valid` stays 1.
- Response registers hold steady while `rspN_valid` is 1 and `rspN_ready` is 0.
- Reset values: `last` = 1 (requester 0 wins the first conflict), `rsp*_valid` = 0, `rsp*_result` = 0, `rsp*_zero` = 0.
- Reset mid-operation: in-flight buffered responses are discarded without handshake. The grant is suppressed while `reset` is high, so `req*_ready` = 0 and the ALU outputs are 0.

## Timing
- Latency: a grant in cycle t gives `rspN_valid` = 1 in cycle t+1.
- Throughput: one operation per cycle in aggregate. A single requester with `rspN_ready` held at 1 sustains one operation per cycle.
- Fairness: with both requesters continuously eligible, grants strictly alternate 0,1,0,1…
- Combinational paths:
  - `req*_valid` / `rsp*_ready` to `req*_ready`.
  - `req*_s1`, `req*_s2`, `req*_ctrl` to `alu_*`.
  - `alu_result` / `alu_zero` to the response register D inputs.
- Handshake rule: requesters must not derive `reqN_valid` from `reqN_ready`. A requester whose valid is refused keeps valid asserted with operands stable until it is granted.
- No path from `alu_result` to any output within the same cycle.

## Structure
- Shared package `alu_pkg`:
  - `W`, `CW` defaults.
  - ALUControl encoding constants used by the ALU and its requesters. This block treats the code as opaque.
- Sub-module `rr_arb2`: two-way round-robin arbiter. Inputs: eligibility[1:0], `last`. Output: one-hot grant[1:0]. `alu_arbiter` owns the `last` register.
- Per-requester response buffer logic is duplicated inline, not a separate module.

## Test plan
- Reset held 2 cycles with both `req*_valid` = 1 → `req*_ready` = 0, `rsp*_valid` = 0, `alu_s1` = `alu_s2` = `alu_ctrl` = 0 throughout.
- Single op:
  - Stimulus: `req0` s1 = 5, s2 = 7; bench ALU model returns s1+s2.
  - Response: `req0_ready` = 1 and `alu_s1` = 5 in cycle t.
  - Cycle t+1: `rsp0_valid` = 1, `rsp0_result` = 12, `rsp0_zero` = 0.
- Conflict: both requesters valid from the first cycle after reset, `rsp*_ready` = 1 → grants 0,1,0,1 over 4 cycles, each result routed to its own response port.
- Backpressure:
  - `rsp0` full with `rsp0_ready` = 0 and `req0_valid` = 1 → `req0_ready` = 0 and requester 1 granted every cycle.
  - Raise `rsp0_ready` → `req0` granted that same cycle, and `rsp0_result` updates with `rsp0_valid` staying 1.
- Zero flag: s1 = 9, s2 = 9, bench model returns s1−s2 → `rspN_result` = 0, `rspN_zero` = 1.
- Reset mid-op: `rsp1_valid` = 1 unconsumed, assert reset 1 cycle → `rsp1_valid` = 0 next cycle; the next both-valid cycle grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath widths and the ALUControl encoding
// used by the ALU and its requesters.
package alu_pkg;

    localparam int unsigned W_DEF  = 32;
    localparam int unsigned CW_DEF = 3;

    typedef enum logic [CW_DEF-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone eligible requester always wins, and on a
// conflict the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = elig;
        if (&elig) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external single-cycle ALU between two requesters, with round-robin
// grant and a one-entry response buffer per requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_s1,
    input  logic [W-1:0]  req0_s2,
    input  logic [CW-1:0] req0_ctrl,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_s1,
    input  logic [W-1:0]  req1_s2,
    input  logic [CW-1:0] req1_ctrl,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [W-1:0]  rsp0_result,
    output logic          rsp0_zero,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [W-1:0]  rsp1_result,
    output logic          rsp1_zero,
    output logic [W-1:0]  alu_s1,
    output logic [W-1:0]  alu_s2,
    output logic [CW-1:0] alu_ctrl,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_zero
);

    logic         last_q, last_d;
    logic         rsp0_valid_q, rsp0_valid_d;
    logic [W-1:0] rsp0_result_q, rsp0_result_d;
    logic         rsp0_zero_q, rsp0_zero_d;
    logic         rsp1_valid_q, rsp1_valid_d;
    logic [W-1:0] rsp1_result_q, rsp1_result_d;
    logic         rsp1_zero_q, rsp1_zero_d;
    logic [1:0]   elig;
    logic [1:0]   grant;

    // A buffer being drained this cycle counts as free; reset blocks all grants.
    always_comb begin
        elig[0] = !reset && req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig[1] = !reset && req1_valid && (!rsp1_valid_q || rsp1_ready);
    end

    rr_arb2 u_rr_arb2 (
        .elig  (elig),
        .last  (last_q),
        .grant (grant)
    );

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;

    always_comb begin
        alu_s1   = '0;
        alu_s2   = '0;
        alu_ctrl = '0;
        if (grant[0]) begin
            alu_s1   = req0_s1;
            alu_s2   = req0_s2;
            alu_ctrl = req0_ctrl;
        end else if (grant[1]) begin
            alu_s1   = req1_s1;
            alu_s2   = req1_s2;
            alu_ctrl = req1_ctrl;
        end
    end

    always_comb begin
        last_d        = last_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;

        // A grant wins over a same-cycle drain, so the buffer stays full.
        if (grant[0]) begin
            last_d        = 1'b0;
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
        end else if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        if (grant[1]) begin
            last_d        = 1'b1;
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
        end else if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q        <= 1'b1;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            last_q        <= last_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

endmodule
